// File: rtl/tawas_regfile.sv
//------------------------------------------------------------------------------
// Module      : tawas_regfile
// Description : Dual-slice 8x32 general register file for the Tawas core.
//               Three combinational read ports (AU A/B, LS), two write-back
//               ports (AU, LS) targeting the slice registered one cycle
//               earlier, with same-cycle write-to-read forwarding.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tawas_regfile (
  input  logic        CLK,
  input  logic        RST,

  input  logic        SLICE,

  input  logic [2:0]  AU_RA_SEL,
  output logic [31:0] AU_RA,
  input  logic [2:0]  AU_RB_SEL,
  output logic [31:0] AU_RB,
  input  logic [2:0]  LS_RA_SEL,
  output logic [31:0] LS_RA,

  input  logic        AU_RC_VLD,
  input  logic [2:0]  AU_RC_SEL,
  input  logic [31:0] AU_RC,
  input  logic        LS_RC_VLD,
  input  logic [2:0]  LS_RC_SEL,
  input  logic [31:0] LS_RC,

  output logic        WR_CONFLICT,
  output logic        WR_SLICE
);

  localparam int unsigned C_NREGS = 8;

  logic [31:0] bank0_q [C_NREGS];
  logic [31:0] bank1_q [C_NREGS];
  logic [31:0] bank0_d [C_NREGS];
  logic [31:0] bank1_d [C_NREGS];

  logic        wr_slice_q;
  logic        conflict_q;
  logic        conflict_d;

  // Read-bank view for the slice currently issuing
  logic [31:0] rd_bank [C_NREGS];

  // Forwarding is only meaningful when write-back and read hit the same
  // bank; it is suppressed during reset so reads show the cleared storage.
  logic        fwd_en;
  assign fwd_en = !RST && (wr_slice_q == SLICE);

  // Both units write to the bank of the slice that issued last cycle;
  // AU is applied last so it wins an index collision.
  always_comb begin
    bank0_d = bank0_q;
    bank1_d = bank1_q;
    if (LS_RC_VLD) begin
      if (wr_slice_q) bank1_d[LS_RC_SEL] = LS_RC;
      else            bank0_d[LS_RC_SEL] = LS_RC;
    end
    if (AU_RC_VLD) begin
      if (wr_slice_q) bank1_d[AU_RC_SEL] = AU_RC;
      else            bank0_d[AU_RC_SEL] = AU_RC;
    end
  end

  assign conflict_d = AU_RC_VLD && LS_RC_VLD && (AU_RC_SEL == LS_RC_SEL);

  // Storage, write-bank tracking and collision flag; reset clears everything
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < C_NREGS; i++) begin
        bank0_q[i] <= '0;
        bank1_q[i] <= '0;
      end
      wr_slice_q <= 1'b0;
      conflict_q <= 1'b0;
    end else begin
      for (int i = 0; i < C_NREGS; i++) begin
        bank0_q[i] <= bank0_d[i];
        bank1_q[i] <= bank1_d[i];
      end
      wr_slice_q <= SLICE;
      conflict_q <= conflict_d;
    end
  end

  // Select the stored bank for the issuing slice
  always_comb begin
    for (int i = 0; i < C_NREGS; i++) begin
      rd_bank[i] = SLICE ? bank1_q[i] : bank0_q[i];
    end
  end

  // Read ports: AU forward, then LS forward, then stored data
  logic [2:0]  rd_sel  [3];
  logic [31:0] rd_data [3];

  assign rd_sel[0] = AU_RA_SEL;
  assign rd_sel[1] = AU_RB_SEL;
  assign rd_sel[2] = LS_RA_SEL;

  generate
    for (genvar p = 0; p < 3; p++) begin : g_rd_port
      assign rd_data[p] =
        (fwd_en && AU_RC_VLD && (AU_RC_SEL == rd_sel[p])) ? AU_RC :
        (fwd_en && LS_RC_VLD && (LS_RC_SEL == rd_sel[p])) ? LS_RC :
        rd_bank[rd_sel[p]];
    end
  endgenerate

  assign AU_RA       = rd_data[0];
  assign AU_RB       = rd_data[1];
  assign LS_RA       = rd_data[2];
  assign WR_CONFLICT = conflict_q;
  assign WR_SLICE    = wr_slice_q;

endmodule

`default_nettype wire

// File: tb/tb_tawas_regfile.sv
//------------------------------------------------------------------------------
// Module      : tb_tawas_regfile
// Description : Directed self-checking bench for tawas_regfile.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_tawas_regfile;

  logic        CLK;
  logic        RST;
  logic        SLICE;
  logic [2:0]  AU_RA_SEL, AU_RB_SEL, LS_RA_SEL;
  logic [31:0] AU_RA, AU_RB, LS_RA;
  logic        AU_RC_VLD, LS_RC_VLD;
  logic [2:0]  AU_RC_SEL, LS_RC_SEL;
  logic [31:0] AU_RC, LS_RC;
  logic        WR_CONFLICT, WR_SLICE;

  int n_tests;
  int n_fail;

  tawas_regfile u_dut (
    .CLK         (CLK),
    .RST         (RST),
    .SLICE       (SLICE),
    .AU_RA_SEL   (AU_RA_SEL),
    .AU_RA       (AU_RA),
    .AU_RB_SEL   (AU_RB_SEL),
    .AU_RB       (AU_RB),
    .LS_RA_SEL   (LS_RA_SEL),
    .LS_RA       (LS_RA),
    .AU_RC_VLD   (AU_RC_VLD),
    .AU_RC_SEL   (AU_RC_SEL),
    .AU_RC       (AU_RC),
    .LS_RC_VLD   (LS_RC_VLD),
    .LS_RC_SEL   (LS_RC_SEL),
    .LS_RC       (LS_RC),
    .WR_CONFLICT (WR_CONFLICT),
    .WR_SLICE    (WR_SLICE)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_writes();
    AU_RC_VLD = 1'b0; AU_RC_SEL = 3'd0; AU_RC = 32'h0;
    LS_RC_VLD = 1'b0; LS_RC_SEL = 3'd0; LS_RC = 32'h0;
  endtask

  // Sweep every slice/index on all three read ports; writes must be idle
  task automatic check_all_zero(input string tag);
    for (int s = 0; s < 2; s++) begin
      for (int r = 0; r < 8; r++) begin
        SLICE = s[0];
        AU_RA_SEL = r[2:0]; AU_RB_SEL = r[2:0]; LS_RA_SEL = r[2:0];
        #1;
        check({tag, "_au_ra"}, AU_RA, 32'h0);
        check({tag, "_au_rb"}, AU_RB, 32'h0);
        check({tag, "_ls_ra"}, LS_RA, 32'h0);
      end
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    RST = 1'b1;
    SLICE = 1'b0;
    AU_RA_SEL = 3'd0; AU_RB_SEL = 3'd0; LS_RA_SEL = 3'd0;
    idle_writes();

    // Reset then read
    tick(); tick();
    check("rst_au_ra_in_reset", AU_RA, 32'h0);
    check("rst_conflict_in_reset", {31'h0, WR_CONFLICT}, 32'h0);
    RST = 1'b0;
    #1;
    check("rst_wr_slice", {31'h0, WR_SLICE}, 32'h0);
    check_all_zero("rst");
    check("rst_conflict", {31'h0, WR_CONFLICT}, 32'h0);

    // Slice isolation: issue in slice 0, write back while slice 1 reads
    tick();
    SLICE = 1'b0;
    tick();
    SLICE = 1'b1;
    AU_RC_VLD = 1'b1; AU_RC_SEL = 3'd3; AU_RC = 32'h12345678;
    AU_RA_SEL = 3'd3;
    #4;
    check("iso_no_fwd_bank1", AU_RA, 32'h0);
    check("iso_wr_slice", {31'h0, WR_SLICE}, 32'h0);
    tick();
    idle_writes();
    #1;
    check("iso_bank1_r3", AU_RA, 32'h0);
    SLICE = 1'b0;
    #1;
    check("iso_bank0_r3", AU_RA, 32'h12345678);

    // Forwarding with SLICE held at 0
    tick();
    AU_RC_VLD = 1'b1; AU_RC_SEL = 3'd5; AU_RC = 32'h1;
    tick();
    idle_writes();
    AU_RA_SEL = 3'd5; AU_RB_SEL = 3'd5;
    #1;
    check("fwd_pre_r5", AU_RA, 32'h1);
    AU_RC_VLD = 1'b1; AU_RC_SEL = 3'd5; AU_RC = 32'hDEADBEEF;
    #3;
    check("fwd_au_ra", AU_RA, 32'hDEADBEEF);
    check("fwd_au_rb", AU_RB, 32'hDEADBEEF);
    tick();
    idle_writes();
    #1;
    check("fwd_stored_r5", AU_RA, 32'hDEADBEEF);

    // Collision on bank0 r2, AU wins
    tick();
    AU_RC_VLD = 1'b1; AU_RC_SEL = 3'd2; AU_RC = 32'hAAAA0000;
    LS_RC_VLD = 1'b1; LS_RC_SEL = 3'd2; LS_RC = 32'h5555FFFF;
    AU_RA_SEL = 3'd2; LS_RA_SEL = 3'd2;
    #4;
    check("col_fwd_au_prio", LS_RA, 32'hAAAA0000);
    check("col_flag_before", {31'h0, WR_CONFLICT}, 32'h0);
    tick();
    idle_writes();
    #1;
    check("col_flag_pulse", {31'h0, WR_CONFLICT}, 32'h1);
    check("col_r2", AU_RA, 32'hAAAA0000);
    tick();
    check("col_flag_clear", {31'h0, WR_CONFLICT}, 32'h0);

    // Two consecutive collisions keep the flag high continuously
    AU_RC_VLD = 1'b1; AU_RC_SEL = 3'd4; AU_RC = 32'h11111111;
    LS_RC_VLD = 1'b1; LS_RC_SEL = 3'd4; LS_RC = 32'h22222222;
    tick();
    check("col2_first", {31'h0, WR_CONFLICT}, 32'h1);
    AU_RC = 32'h33333333; LS_RC = 32'h44444444;
    tick();
    idle_writes();
    check("col2_second", {31'h0, WR_CONFLICT}, 32'h1);
    AU_RA_SEL = 3'd4;
    #1;
    check("col2_r4", AU_RA, 32'h33333333);
    tick();
    check("col2_clear", {31'h0, WR_CONFLICT}, 32'h0);

    // Dual distinct writes in one cycle
    AU_RC_VLD = 1'b1; AU_RC_SEL = 3'd1; AU_RC = 32'd7;
    LS_RC_VLD = 1'b1; LS_RC_SEL = 3'd6; LS_RC = 32'd9;
    AU_RA_SEL = 3'd1; LS_RA_SEL = 3'd6;
    #4;
    check("dual_fwd_ls", LS_RA, 32'd9);
    check("dual_fwd_au", AU_RA, 32'd7);
    tick();
    idle_writes();
    #1;
    check("dual_conflict", {31'h0, WR_CONFLICT}, 32'h0);
    check("dual_r6", LS_RA, 32'd9);
    check("dual_r1", AU_RA, 32'd7);

    // Valid low: presented data must not land
    AU_RC_SEL = 3'd1; AU_RC = 32'hBAD0BAD0;
    LS_RC_SEL = 3'd6; LS_RC = 32'hBAD1BAD1;
    tick();
    check("novld_r1", AU_RA, 32'd7);
    check("novld_r6", LS_RA, 32'd9);

    // Reset mid-write: preload bank1, then reset alongside an AU write
    SLICE = 1'b1;
    tick();
    for (int r = 0; r < 8; r++) begin
      AU_RC_VLD = 1'b1; AU_RC_SEL = r[2:0]; AU_RC = 32'h100 + r;
      tick();
    end
    idle_writes();
    AU_RA_SEL = 3'd4;
    #1;
    check("pre_bank1_r4", AU_RA, 32'h104);
    tick();
    AU_RC_VLD = 1'b1; AU_RC_SEL = 3'd7; AU_RC = 32'hCAFEF00D;
    AU_RA_SEL = 3'd7;
    RST = 1'b1;
    #1;
    check("rst_mid_fwd_gated", AU_RA, 32'h0);
    tick();
    idle_writes();
    RST = 1'b0;
    #1;
    check("rst_mid_wr_slice", {31'h0, WR_SLICE}, 32'h0);
    check("rst_mid_conflict", {31'h0, WR_CONFLICT}, 32'h0);
    check_all_zero("rst_mid");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
